// File: rtl/dialogue_rx_if.sv
// Bundle between the peer link and the dialogue receiver: raw inputs from the
// other board plus the decoded event/status outputs.
interface dialogue_rx_if;
   logic [2:0] dialogue_in;
   logic       rst_n_in;
   logic [2:0] code;
   logic       code_valid;
   logic [1:0] state;
   logic [7:0] peer_score;
   logic [7:0] peer_wrong;
   logic       proto_err;
   logic       link_lost;

   modport master (
      output dialogue_in, rst_n_in,
      input  code, code_valid, state, peer_score, peer_wrong, proto_err, link_lost
   );
   modport slave (
      input  dialogue_in, rst_n_in,
      output code, code_valid, state, peer_score, peer_wrong, proto_err, link_lost
   );
endinterface

// File: rtl/dialogue_rx.sv
// Receive side of the BrainWars dialogue link: sync, glitch filter, event decode,
// peer phase tracking, score counting, protocol error and link timeout flags.
module dialogue_rx #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 6600
) (
   input logic        clk,
   input logic        rst,
   dialogue_rx_if.slave bus
);
   localparam logic [2:0]  C_IDLE    = 3'd0;
   localparam logic [2:0]  C_READY   = 3'd1;
   localparam logic [2:0]  C_START   = 3'd2;
   localparam logic [2:0]  C_CORRECT = 3'd3;
   localparam logic [2:0]  C_WRONG   = 3'd4;
   localparam logic [2:0]  C_FINISH  = 3'd5;
   localparam logic [2:0]  C_RSV6    = 3'd6;
   localparam logic [3:0]  ACC_REPS  = 4'(STABLE_CYCLES - 1);
   localparam logic [15:0] TMO       = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_WAIT_PEER, S_READY, S_PLAYING, S_DONE} state_t;

   logic [2:0]  din_s1, din_s2, prev, filt, code_q;
   logic        rn_s1, rn_s2, vld_q, perr_q, lost_q;
   logic [3:0]  cnt, reps;
   logic [7:0]  score_q, wrong_q;
   logic [15:0] tcnt;
   state_t      st, nxt;
   logic        peer_rst, accept, evt, inc_sc, inc_wr, set_err;

   // Peer reset sync idles high so a local reset does not look like a peer reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_s1 <= '0;
         din_s2 <= '0;
         rn_s1  <= 1'b1;
         rn_s2  <= 1'b1;
      end else begin
         din_s1 <= bus.dialogue_in;
         din_s2 <= din_s1;
         rn_s1  <= bus.rst_n_in;
         rn_s2  <= rn_s1;
      end
   end

   assign peer_rst = !rn_s2;
   // reps = repeats of the current sample beyond the first one
   assign reps     = (din_s2 != prev) ? 4'd0 : ((cnt == 4'hF) ? 4'hF : cnt + 4'd1);
   assign accept   = (reps >= ACC_REPS) && (din_s2 != filt);
   assign evt      = accept && (din_s2 != C_IDLE);

   always_comb begin
      nxt     = st;
      inc_sc  = 1'b0;
      inc_wr  = 1'b0;
      set_err = 1'b0;
      if (evt) begin
         if (st != S_DONE && din_s2 >= C_RSV6) set_err = 1'b1;
         else begin
            unique case (st)
               S_WAIT_PEER: if (din_s2 == C_READY) nxt = S_READY; else set_err = 1'b1;
               S_READY: begin
                  if (din_s2 == C_START) nxt = S_PLAYING;
                  else if (din_s2 != C_READY) set_err = 1'b1;
               end
               S_PLAYING: begin
                  case (din_s2)
                     C_CORRECT: inc_sc  = 1'b1;
                     C_WRONG:   inc_wr  = 1'b1;
                     C_FINISH:  nxt     = S_DONE;
                     default:   set_err = 1'b1;
                  endcase
               end
               S_DONE: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || peer_rst) st <= S_WAIT_PEER;
      else                 st <= nxt;
   end

   always_ff @(posedge clk) begin
      if (rst || peer_rst) begin
         prev    <= '0;
         cnt     <= '0;
         filt    <= '0;
         code_q  <= '0;
         vld_q   <= 1'b0;
         score_q <= '0;
         wrong_q <= '0;
         perr_q  <= 1'b0;
         lost_q  <= 1'b0;
         tcnt    <= '0;
      end else begin
         prev  <= din_s2;
         cnt   <= reps;
         vld_q <= evt;
         if (accept) filt <= din_s2;
         if (evt) code_q <= din_s2;
         if (inc_sc && score_q != 8'hFF) score_q <= score_q + 8'd1;
         if (inc_wr && wrong_q != 8'hFF) wrong_q <= wrong_q + 8'd1;
         if (set_err) perr_q <= 1'b1;
         // An event on the expiry edge wins, so expiry is only checked without one.
         if (evt) tcnt <= '0;
         else if (st == S_PLAYING && tcnt != TMO) begin
            tcnt <= tcnt + 16'd1;
            if (tcnt + 16'd1 == TMO) lost_q <= 1'b1;
         end
      end
   end

   assign bus.code       = code_q;
   assign bus.code_valid = vld_q;
   assign bus.state      = st;
   assign bus.peer_score = score_q;
   assign bus.peer_wrong = wrong_q;
   assign bus.proto_err  = perr_q;
   assign bus.link_lost  = lost_q;
endmodule

// File: tb/tb_dialogue_rx.sv
// Bench for dialogue_rx: vector table for the main game sequence, scoreboard on
// code_valid pulses, and hand sequences for glitch, timeout, saturation and resets.
module tb_dialogue_rx;
   logic clk = 1'b0;
   logic rst;
   dialogue_rx_if bus();

   dialogue_rx #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] din;
      int         hold;
      bit         pulse;
      logic [1:0] st;
      logic [7:0] sc;
      logic [7:0] wr;
      bit         perr;
   } vec_t;

   int         n_checks = 0;
   int         n_err    = 0;
   int         pulse_cnt = 0;
   logic [2:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [2:0] cd, input logic [1:0] st,
                          input logic [7:0] sc, input logic [7:0] wr,
                          input bit perr, input bit lost);
      chk({nm, "_code"},  32'(bus.code), 32'(cd));
      chk({nm, "_state"}, 32'(bus.state), 32'(st));
      chk({nm, "_score"}, 32'(bus.peer_score), 32'(sc));
      chk({nm, "_wrong"}, 32'(bus.peer_wrong), 32'(wr));
      chk({nm, "_perr"},  32'(bus.proto_err), 32'(perr));
      chk({nm, "_lost"},  32'(bus.link_lost), 32'(lost));
   endtask

   task automatic drive(input logic [2:0] c, input int n, input bit pulse);
      if (pulse) exp_q.push_back(c);
      bus.dialogue_in = c;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulse(input string nm, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (bus.code_valid === 1'b1) seen = 1'b1;
      end
      chk({nm, "_pulse_seen"}, 32'(seen), 32'd1);
   endtask

   // Scoreboard: every pulse must match the oldest expected code.
   always @(negedge clk) begin
      if (bus.code_valid === 1'b1) begin
         pulse_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_pulse: got code %0d expected no pulse", bus.code);
         end else begin
            chk("pulse_code", 32'(bus.code), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      vec_t tbl[11];
      int   base;
      tbl[0]  = '{3'd0, 7, 1'b0, 2'd1, 8'd0, 8'd0, 1'b0};
      tbl[1]  = '{3'd2, 7, 1'b1, 2'd2, 8'd0, 8'd0, 1'b0};
      tbl[2]  = '{3'd3, 7, 1'b1, 2'd2, 8'd1, 8'd0, 1'b0};
      tbl[3]  = '{3'd0, 7, 1'b0, 2'd2, 8'd1, 8'd0, 1'b0};
      tbl[4]  = '{3'd3, 7, 1'b1, 2'd2, 8'd2, 8'd0, 1'b0};
      tbl[5]  = '{3'd0, 7, 1'b0, 2'd2, 8'd2, 8'd0, 1'b0};
      tbl[6]  = '{3'd3, 7, 1'b1, 2'd2, 8'd3, 8'd0, 1'b0};
      tbl[7]  = '{3'd0, 7, 1'b0, 2'd2, 8'd3, 8'd0, 1'b0};
      tbl[8]  = '{3'd4, 7, 1'b1, 2'd2, 8'd3, 8'd1, 1'b0};
      tbl[9]  = '{3'd0, 7, 1'b0, 2'd2, 8'd3, 8'd1, 1'b0};
      tbl[10] = '{3'd5, 7, 1'b1, 2'd3, 8'd3, 8'd1, 1'b0};

      bus.dialogue_in = 3'd0;
      bus.rst_n_in    = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_vld", 32'(bus.code_valid), 32'd0);
      chk_all("rst", 3'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // READY latency: pulse only on the 6th cycle after the change
      base = pulse_cnt;
      exp_q.push_back(3'd1);
      bus.dialogue_in = 3'd1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         chk($sformatf("lat_vld_c%0d", i), 32'(bus.code_valid), 32'(i == 6));
      end
      chk_all("lat", 3'd1, 2'd1, 8'd0, 8'd0, 1'b0, 1'b0);

      for (int r = 0; r < 11; r++) begin
         drive(tbl[r].din, tbl[r].hold, tbl[r].pulse);
         chk($sformatf("tbl%0d_state", r), 32'(bus.state), 32'(tbl[r].st));
         chk($sformatf("tbl%0d_score", r), 32'(bus.peer_score), 32'(tbl[r].sc));
         chk($sformatf("tbl%0d_wrong", r), 32'(bus.peer_wrong), 32'(tbl[r].wr));
         chk($sformatf("tbl%0d_perr", r), 32'(bus.proto_err), 32'(tbl[r].perr));
      end
      chk("seq_pulses", 32'(pulse_cnt - base), 32'd7);
      chk("seq_queue", 32'(exp_q.size()), 32'd0);

      // Back to PLAYING, then glitch and reserved code
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst2_state", 32'(bus.state), 32'd0);
      drive(3'd1, 7, 1'b1);
      drive(3'd0, 7, 1'b0);
      drive(3'd2, 7, 1'b1);
      drive(3'd3, 3, 1'b0);
      drive(3'd0, 7, 1'b0);
      chk("glitch_score", 32'(bus.peer_score), 32'd0);
      exp_q.push_back(3'd7);
      bus.dialogue_in = 3'd7;
      wait_pulse("rsv7", 12);
      bus.dialogue_in = 3'd0;
      chk("rsv7_perr", 32'(bus.proto_err), 32'd1);
      chk("rsv7_state", 32'(bus.state), 32'd2);

      // Timeout counted from the reserved-code event
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 19) chk("tmo_lost_19", 32'(bus.link_lost), 32'd0);
         if (k == 20) chk("tmo_lost_20", 32'(bus.link_lost), 32'd1);
      end
      drive(3'd3, 7, 1'b1);
      chk_all("post_tmo", 3'd3, 2'd2, 8'd1, 8'd0, 1'b1, 1'b1);

      // Score saturation
      for (int p = 0; p < 260; p++) begin
         drive(3'd0, 6, 1'b0);
         drive(3'd3, 6, 1'b1);
      end
      drive(3'd0, 6, 1'b0);
      chk("sat_score", 32'(bus.peer_score), 32'd255);

      // Peer reset with READY arriving at the same time
      bus.rst_n_in    = 1'b0;
      bus.dialogue_in = 3'd1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("prst_vld_c%0d", k), 32'(bus.code_valid), 32'd0);
      end
      bus.rst_n_in = 1'b1;
      @(negedge clk);
      chk("prst_vld", 32'(bus.code_valid), 32'd0);
      chk_all("prst", 3'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      exp_q.push_back(3'd1);
      wait_pulse("prst_ready", 12);
      chk("prst_ready_state", 32'(bus.state), 32'd1);

      // Local reset in the middle of filtering a START
      bus.dialogue_in = 3'd2;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_all("mid_rst", 3'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      exp_q.push_back(3'd2);
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         chk($sformatf("mid_vld_c%0d", j), 32'(bus.code_valid), 32'(j == 6));
      end
      chk("mid_perr", 32'(bus.proto_err), 32'd1);
      chk("mid_state", 32'(bus.state), 32'd0);
      repeat (3) @(negedge clk);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/dialogue_rx.md
# dialogue_rx

Receive side of the two-board dialogue link in the BrainWars game. Samples the opponent's 3-bit `dialogue_in` bus and peer reset `rst_n_in`, synchronizes and glitch-filters them, and decodes each new code into a one-cycle event. Tracks the opponent's game phase, counts correct and wrong answers, and flags protocol errors and link timeouts. Outputs feed the local game FSM and the LCD/SSD screens. The transmit side is the count-down and game logic that drives `dialogue_out`.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required to accept a code (range 1–15).
- `TIMEOUT_CYCLES`, default 6600: cycles without an accepted event in PLAYING before `link_lost` sets. Default is 100 s at 66 Hz. 16-bit.
- `clk` in 1: game clock. Same clock as the dialogue transmitter.
- `rst` in 1: synchronous, active-high reset.
- `dialogue_in` in 3: raw code from the other board. Asynchronous.
- `rst_n_in` in 1: raw peer reset, active low. Asynchronous.
- `code` out 3: last accepted non-IDLE code.
- `code_valid` out 1: one-cycle pulse when `code` updates.
- `state` out 2: peer phase. 0 WAIT_PEER, 1 READY, 2 PLAYING, 3 DONE.
- `peer_score` out 8: count of CORRECT events. Saturates at 255.
- `peer_wrong` out 8: count of WRONG events. Saturates at 255.
- `proto_err` out 1: sticky; illegal or reserved code seen.
- `link_lost` out 1: sticky; timeout expired in PLAYING.

## Operation
- Code map:
  - 0 IDLE
  - 1 READY
  - 2 START
  - 3 CORRECT
  - 4 WRONG
  - 5 FINISH
  - 6 and 7 reserved
- The transmitter returns to IDLE between two identical consecutive codes. Only a change of the filtered value to a non-IDLE code is an event.
- Synchronizer: two flops each on `dialogue_in` and `rst_n_in`.
- Filter:
  - Counter clears when the synchronized code differs from its previous sample; otherwise it increments, saturating.
  - A value is accepted when it has been stable for `STABLE_CYCLES` samples.
  - The filtered register updates only if the accepted value differs from it.
- On acceptance of a non-IDLE value: `code` ← value, and `code_valid` = 1 for exactly one cycle. Acceptance of IDLE updates the filtered register only; no pulse.
- FSM, applied per event:
  - WAIT_PEER: READY → READY state. Any other event → `proto_err`, stay.
  - READY: START → PLAYING. READY → stay, no error. Any other event → `proto_err`.
  - PLAYING: CORRECT → `peer_score`+1. WRONG → `peer_wrong`+1. FINISH → DONE. READY or START → `proto_err`, stay.
  - DONE: all events ignored, no error. Leave only via `rst` or peer reset.
  - Reserved code 6 or 7 in any state except DONE → `proto_err`; no state change, no count.
- Timeout:
  - A 16-bit counter runs only in PLAYING and clears on every accepted event.
  - Reaching `TIMEOUT_CYCLES` sets `link_lost`, and the counter holds.
  - `link_lost` does not change state.
- Peer reset: a synchronized `rst_n_in` = 0 acts as a soft reset.
  - Resets state, counters, `code`, filter, timeout counter and `proto_err`.
  - Suppresses `code_valid`.
  - `link_lost` also clears.
  - Held for as long as the synchronized `rst_n_in` stays low.

## Timing
- Reset (`rst` = 1 at a clock edge): all outputs 0 on the next cycle. State is WAIT_PEER; synchronizers, filter and counters are cleared. Reset has priority over everything.
- Latency: `dialogue_in` changed and held from before edge 0 gives `code_valid` high in the cycle after edge `STABLE_CYCLES`+1. That is `STABLE_CYCLES`+2 cycles. `state` and counters update on the same edge as `code_valid`.
- Glitches: a pulse shorter than `STABLE_CYCLES` cycles at the synchronizer output produces no event.
- Peer reset latency: 2 cycles from the synchronized low to the outputs clearing.
- Simultaneous events:
  - Peer reset and event acceptance on the same edge: peer reset wins, no pulse.
  - Event and timeout expiry on the same edge: the event wins and clears the counter; `link_lost` does not set.
- Saturation: a CORRECT at score 255 still pulses `code_valid`; the count stays 255.
- Mid-operation `rst`: the pending filter count is discarded. A code held through reset release is accepted `STABLE_CYCLES`+2 cycles after release.

## Test plan
- Defaults. Reset, then drive READY held 10 cycles. Expect:
  - `code_valid` pulse at cycle 6 after the change, `code` = 1, `state` = 1.
  - All other outputs 0.
- Sequence READY, IDLE, START, then {CORRECT, IDLE} ×3, {WRONG, IDLE}, FINISH. Expect:
  - `peer_score` = 3, `peer_wrong` = 1, `state` = 3.
  - Exactly 7 pulses, `proto_err` = 0.
- 3-cycle glitch to CORRECT during PLAYING: no pulse, score unchanged. Then code 7: `proto_err` = 1, state stays PLAYING.
- In PLAYING with `TIMEOUT_CYCLES` = 20: hold IDLE. `link_lost` = 1 exactly 20 cycles after the last event. A later CORRECT still counts.
- 260 CORRECT/IDLE pairs: `peer_score` = 255. Then drop `rst_n_in` for 5 cycles: all outputs 0, `state` = WAIT_PEER. Assert READY on the same edge as the peer reset: no pulse.
- Assert `rst` while a START is half-filtered (2 stable samples). Release with START held: pulse exactly 6 cycles after release, `proto_err` = 1 (START in WAIT_PEER).
